// File: rtl/cpu_mul_shift_unit.sv
// Two-stage multiply/shift unit: operands are captured from E into M, and the
// result is computed from M and registered into A.
module cpu_mul_shift_unit #(
    parameter int WIDTH     = 32,
    parameter int HI_ENABLE = 1,
    localparam int SHAMT_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             E_valid,
    input  logic [2:0]       E_op,
    input  logic             E_src1_signed,
    input  logic             E_src2_signed,
    input  logic [WIDTH-1:0] E_src1,
    input  logic [WIDTH-1:0] E_src2,
    input  logic             M_en,
    input  logic             A_en,
    output logic             A_valid,
    output logic [WIDTH-1:0] A_result
);

    typedef enum logic [2:0] {
        OP_MUL  = 3'b000,
        OP_MULH = 3'b001,
        OP_SLL  = 3'b010,
        OP_SRL  = 3'b011,
        OP_SRA  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_RSVD = 3'b111
    } op_t;

    logic               m_valid;
    logic [2:0]         m_op;
    logic               m_s1s;
    logic               m_s2s;
    logic [WIDTH-1:0]   m_src1;
    logic [WIDTH-1:0]   m_src2;

    logic [SHAMT_W-1:0] sh;
    logic [WIDTH-1:0]   mul_lo;
    logic [WIDTH-1:0]   mul_hi;
    logic [WIDTH-1:0]   result;

    function automatic logic [WIDTH-1:0] shift_ra(input logic [WIDTH-1:0] x,
                                                  input logic [SHAMT_W-1:0] s);
        return WIDTH'($signed(x) >>> s);
    endfunction

    // Complementary shift distance; for s=0 it equals WIDTH, so the wrapped term vanishes.
    function automatic logic [WIDTH-1:0] rot_l(input logic [WIDTH-1:0] x,
                                               input logic [SHAMT_W-1:0] s);
        logic [SHAMT_W:0] back;
        back = (SHAMT_W+1)'(WIDTH) - {1'b0, s};
        return (x << s) | (x >> back);
    endfunction

    function automatic logic [WIDTH-1:0] rot_r(input logic [WIDTH-1:0] x,
                                               input logic [SHAMT_W-1:0] s);
        logic [SHAMT_W:0] back;
        back = (SHAMT_W+1)'(WIDTH) - {1'b0, s};
        return (x >> s) | (x << back);
    endfunction

    assign sh = m_src2[SHAMT_W-1:0];

    // Operands are extended to 2*WIDTH per their own signedness; the modulo-2^(2W)
    // product then yields both halves, and the low half is signedness-independent.
    generate
        if (HI_ENABLE != 0) begin : g_hi
            logic [2*WIDTH-1:0] op1_ext;
            logic [2*WIDTH-1:0] op2_ext;
            logic [2*WIDTH-1:0] prod;
            assign op1_ext = {{WIDTH{m_s1s & m_src1[WIDTH-1]}}, m_src1};
            assign op2_ext = {{WIDTH{m_s2s & m_src2[WIDTH-1]}}, m_src2};
            assign prod    = op1_ext * op2_ext;
            assign mul_lo  = prod[WIDTH-1:0];
            assign mul_hi  = prod[2*WIDTH-1:WIDTH];
        end else begin : g_lo
            assign mul_lo = m_src1 * m_src2;
            assign mul_hi = '0;
        end
    endgenerate

    always_comb begin
        result = '0;
        case (op_t'(m_op))
            OP_MUL:  result = mul_lo;
            OP_MULH: result = mul_hi;
            OP_SLL:  result = m_src1 << sh;
            OP_SRL:  result = m_src1 >> sh;
            OP_SRA:  result = shift_ra(m_src1, sh);
            OP_ROL:  result = rot_l(m_src1, sh);
            OP_ROR:  result = rot_r(m_src1, sh);
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid  <= 1'b0;
            m_op     <= '0;
            m_s1s    <= 1'b0;
            m_s2s    <= 1'b0;
            m_src1   <= '0;
            m_src2   <= '0;
            A_valid  <= 1'b0;
            A_result <= '0;
        end else begin
            // Stage 1: E -> M
            if (M_en) begin
                m_valid <= E_valid;
                m_op    <= E_op;
                m_s1s   <= E_src1_signed;
                m_s2s   <= E_src2_signed;
                m_src1  <= E_src1;
                m_src2  <= E_src2;
            end else if (A_en) begin
                m_valid <= 1'b0;
            end
            // Stage 2: M -> A; bubbles leave the last result visible
            if (A_en) begin
                A_valid <= m_valid;
                if (m_valid) begin
                    A_result <= result;
                end
            end
        end
    end

endmodule

// File: doc/cpu_mul_shift_unit.md
# cpu_mul_shift_unit

Parametrised two-stage multiply/shift unit for the CPU datapath. It executes low and high-half multiplies, logical and arithmetic shifts, and rotates on WIDTH-bit operands. Operands issue from the E stage; the result returns in the A stage. It generalises the fixed 32-bit multiply cell with a width parameter, a high-half product, per-op valid tracking and explicit stall/bubble rules.

## Interface

Parameters:
- WIDTH, 32, operand/result width; even, 8..64.
- HI_ENABLE, 1, 1 = implement MULH; 0 = MULH returns zero and the upper-product logic is removed.
- SHAMT_W, $clog2(WIDTH), derived shift-amount width; not overridden.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- E_valid  in  1  an op is presented in E this cycle.
- E_op  in  3  opcode: 000 MUL, 001 MULH, 010 SLL, 011 SRL, 100 SRA, 101 ROL, 110 ROR, 111 reserved.
- E_src1_signed  in  1  src1 is two's complement (MULH only).
- E_src2_signed  in  1  src2 is two's complement (MULH only).
- E_src1  in  WIDTH  operand / shift data.
- E_src2  in  WIDTH  operand / shift amount (low SHAMT_W bits).
- M_en  in  1  stage-1 (E→M) advance enable.
- A_en  in  1  stage-2 (M→A) advance enable.
- A_valid  out  1  A_result holds a newly completed op.
- A_result  out  WIDTH  result.

## Operation

- Stage 1 (M) registers: m_valid, m_op, m_s1s, m_s2s, m_src1, m_src2.
  - On M_en=1, all load from the E inputs.
  - On M_en=0 and A_en=1, m_valid clears (entry consumed); other M registers hold.
  - With both enables 0, everything holds.
- Stage 2 computes combinationally from the M registers and registers into A.
  - On A_en=1: A_valid <= m_valid. A_result loads the computed value only when m_valid=1; otherwise it holds.
  - On A_en=0: A_valid and A_result hold.
- Arithmetic:
  - MUL: low WIDTH bits of src1*src2. These are identical for any signedness.
  - MULH: upper WIDTH bits of the 2·WIDTH product. Each operand is sign- or zero-extended per its own flag, so mixed signed×unsigned is supported.
  - Shift amount sh = src2[SHAMT_W-1:0]; higher bits are ignored.
  - SLL/SRL: zero fill. SRA: fill with src1[WIDTH-1]. ROL/ROR: circular.
  - sh=0 returns src1 unchanged for all shift/rotate ops.
  - Signed flags are ignored for shift ops.
  - Op 111, and MULH with HI_ENABLE=0, return 0 with A_valid still asserted.
- Reset: m_valid, A_valid, A_result and all M registers go to 0 asynchronously. In-flight ops are discarded and no result is produced after release.

## Timing

- Latency: an op sampled at edge n (E_valid=1, M_en=1), with A_en=1 at edge n+1, appears on A_result/A_valid after edge n+1. That is 2 cycles issue-to-visible.
- Throughput: one op per cycle when both enables are 1.
- Stall of A (A_en=0): outputs frozen. If M_en=1 during the stall, the M entry is overwritten; the CPU guarantees M_en=0 whenever A_en=0.
- M_en=0 with A_en=1: exactly one A_valid pulse for the held entry, then bubbles (A_valid=0, A_result held).
- Simultaneous M_en=1 and A_en=1: A takes the old M entry while M takes the new E entry, in the same edge.
- E_valid=0 with M_en=1 inserts a bubble.
- Reset assertion takes effect without a clock edge. The first op is accepted at the first rising edge after reset_n deasserts.
- Critical path is the WIDTH×WIDTH multiplier. Synthesis maps it to dedicated multiplier blocks.

## Test plan

- MUL, WIDTH=32, src1=0x00000007, src2=0xFFFFFFFD, both enables 1 → A_result=0xFFFFFFEB and A_valid=1 exactly 2 cycles after issue.
- MULH with src1=src2=0xFFFFFFFF:
  - signed/signed → 0x00000000
  - unsigned/unsigned → 0xFFFFFFFE
  - src1 signed, src2 unsigned → 0xFFFFFFFF
  - issued back-to-back, results appear on 3 consecutive cycles.
- Shifts with src1=0x80000001, src2=0x00000021 (sh=1):
  - SLL → 0x00000002
  - SRL → 0x40000000
  - SRA → 0xC0000000
  - ROL → 0x00000003
  - ROR → 0xC0000000
  - with src2=0x20 (sh=0), every shift op → 0x80000001.
- Stalls:
  - Hold A_en=0 (and M_en=0) for 3 cycles → A_result/A_valid unchanged.
  - Then M_en=0, A_en=1 for 3 cycles → a single A_valid pulse, then A_valid=0 with A_result held.
- Reset mid-operation: issue 2 MULs, assert reset_n=0 between clock edges → A_valid=0 and A_result=0 immediately; after release with E_valid=0, A_valid stays 0.
- Configuration and reserved op:
  - HI_ENABLE=0, MULH 0xFFFFFFFF×0xFFFFFFFF unsigned → 0x00000000 with A_valid=1.
  - Op 111 → 0x00000000 with A_valid=1.
  - WIDTH=16, MUL 0x0100×0x0100 → 0x0000; MULH unsigned → 0x0001.
